// File: rtl/accum_sched_pkg.sv
// Shared types and default widths for the accum_sched scheduler and its
// accumulator datapath.
package accum_sched_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 26;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCUM,
    RESULT
  } state_t;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_ACCUM = 2'd1,
    OP_HOLD  = 2'd2
  } op_t;

endpackage

// File: rtl/accum_sched_if.sv
// Request, sample and result bus between the requesters, the consumer
// (master side) and the accum_sched scheduler (slave side).
interface accum_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic                   res_valid;
  logic [DATA_W-1:0]      res_data;
  logic                   res_ovf;
  logic [ID_W-1:0]        res_id;
  logic                   res_ready;
  logic                   busy;

  modport master (
    output req, len, in_valid, in_data, res_ready,
    input  grant, in_ready, res_valid, res_data, res_ovf, res_id, busy
  );

  modport slave (
    input  req, len, in_valid, in_data, res_ready,
    output grant, in_ready, res_valid, res_data, res_ovf, res_id, busy
  );

endinterface

// File: rtl/accum_core.sv
// Accumulator datapath: clears, adds a zero-extended sample (wrapping at
// 2^ACC_W) or holds, as commanded by the scheduler.
module accum_core
  import accum_sched_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  op_t               op,
  input  logic [DATA_W-1:0] in_data,
  output logic [ACC_W-1:0]  acc
);

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      case (op)
        OP_CLEAR: acc <= '0;
        OP_ACCUM: acc <= acc + ACC_W'(in_data);
        default:  acc <= acc;
      endcase
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Round-robin scheduler sharing one accumulator among N_REQ requesters:
// grant, clear, accumulate a burst of len samples, then hand back the sum.
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  accum_sched_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  state_t            state, state_nx;
  op_t               op;
  logic [ID_W-1:0]   rr_ptr, id_q, pick, scan_idx;
  logic              found;
  logic [LEN_W-1:0]  len_q, cnt;
  logic [N_REQ-1:0]  grant_q;
  logic [ACC_W-1:0]  acc;
  logic              beat;

  assign beat = (state == ACCUM) && bus.in_valid;

  // Search upward from the requester after the last one served, wrapping,
  // so the one just served has the lowest priority.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (scan_idx == ID_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_nx = state;
    op       = OP_HOLD;
    case (state)
      IDLE:   if (found) state_nx = GRANT;
      GRANT: begin
        op       = OP_CLEAR;
        state_nx = (len_q == '0) ? RESULT : ACCUM;
      end
      ACCUM: begin
        if (bus.in_valid) begin
          op = OP_ACCUM;
          if (cnt == len_q - 1'b1) state_nx = RESULT;
        end
      end
      RESULT: if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      len_q   <= '0;
      cnt     <= '0;
      grant_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        id_q    <= pick;
        len_q   <= bus.len[int'(pick)*LEN_W +: LEN_W];
        grant_q <= N_REQ'(1) << pick;
      end
      if (state == GRANT) cnt <= '0;
      if (beat) cnt <= cnt + 1'b1;
      if (state == RESULT && bus.res_ready) begin
        rr_ptr  <= id_q;
        grant_q <= '0;
      end
    end
  end

  accum_core #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .in_data (bus.in_data),
    .acc     (acc)
  );

  assign bus.grant     = grant_q;
  assign bus.in_ready  = (state == ACCUM);
  assign bus.res_valid = (state == RESULT);
  assign bus.res_data  = acc[DATA_W-1:0];
  assign bus.res_ovf   = |acc[ACC_W-1:DATA_W];
  assign bus.res_id    = id_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched: directed bursts plus random traffic
// against a transaction-level round-robin / sum model.
module tb_accum_sched;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 26;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accum_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  accum_sched #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int last_id;
  int len_tab [N_REQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_len(input int i, input int v);
    len_tab[i] = v;
    bus.len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  // Reference arbitration: first requester above the last one served, wrapping.
  function automatic int rr_winner(input logic [N_REQ-1:0] r, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  // smode: 0 random, 1 constant cval, 2 cval*(beat+1), 3 cval*(winner+1)
  // vmode: 0 continuous, 1 toggling 1,0,1,..., 2 random ~70%
  task automatic do_burst(input logic [N_REQ-1:0] reqv, input int smode, input int cval,
                          input int vmode, input int hold, input bit early_rdy,
                          input bit disturb, input int abort_after);
    int w, n, beats, cyc;
    longint sum;
    logic rdy_now;
    logic [ACC_W-1:0] exp_acc;
    logic [DATA_W-1:0] exp_data;
    logic exp_ovf;

    bus.req = reqv;
    w = rr_winner(reqv, last_id);
    n = len_tab[w];
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant == '0 && cyc < 4);
    check("grant_latency", 64'(cyc), 64'd1);
    check("grant", 64'(bus.grant), 64'(1 << w));
    check("busy_grant", 64'(bus.busy), 64'd1);
    check("in_ready_grant", 64'(bus.in_ready), 64'd0);

    bus.in_valid = 1'($urandom_range(1));
    bus.in_data  = DATA_W'($urandom);
    if (disturb) begin
      set_len(w, $urandom_range(255));
      bus.req = N_REQ'($urandom);
    end
    bus.res_ready = early_rdy;
    @(negedge clk);

    beats = 0;
    sum   = 0;
    cyc   = 0;
    while (beats < n && cyc < 4000) begin
      if (abort_after >= 0 && beats == abort_after) return;
      if (cyc == 0) check("in_ready_rise", 64'(bus.in_ready), 64'd1);
      rdy_now = bus.in_ready;
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = ($urandom_range(9) < 7);
      endcase
      case (smode)
        0:       bus.in_data = DATA_W'($urandom);
        1:       bus.in_data = DATA_W'(cval);
        2:       bus.in_data = DATA_W'(cval * (beats + 1));
        default: bus.in_data = DATA_W'(cval * (w + 1));
      endcase
      @(negedge clk);
      cyc++;
      if (rdy_now && bus.in_valid) begin
        sum += longint'(bus.in_data);
        beats++;
      end
    end
    check("beats", 64'(beats), 64'(n));

    bus.in_valid = 1'($urandom_range(1));
    bus.in_data  = DATA_W'($urandom);
    exp_acc  = ACC_W'(sum);
    exp_data = exp_acc[DATA_W-1:0];
    exp_ovf  = |exp_acc[ACC_W-1:DATA_W];
    check("res_valid", 64'(bus.res_valid), 64'd1);
    check("in_ready_result", 64'(bus.in_ready), 64'd0);
    check("res_data", 64'(bus.res_data), 64'(exp_data));
    check("res_ovf", 64'(bus.res_ovf), 64'(exp_ovf));
    check("res_id", 64'(bus.res_id), 64'(w));

    if (!early_rdy) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 64'(bus.res_valid), 64'd1);
        check("hold_data", 64'(bus.res_data), 64'(exp_data));
        check("hold_id", 64'(bus.res_id), 64'(w));
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("res_done", 64'(bus.res_valid), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_grant", 64'(bus.grant), 64'd0);
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    last_id = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 64'(bus.grant), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(bus.res_data), 64'd0);
    check({tag, "_res_ovf"}, 64'(bus.res_ovf), 64'd0);
    check({tag, "_res_id"}, 64'(bus.res_id), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_len(i, 0);
    last_id = N_REQ - 1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst 10,20,30.
    set_len(0, 3);
    do_burst(4'b0001, 2, 10, 0, 0, 1'b1, 1'b0, -1);

    // Round-robin with all requests held, len=1, sample 5*(id+1).
    for (int i = 0; i < N_REQ; i++) set_len(i, 1);
    for (int b = 0; b < 5; b++) do_burst(4'b1111, 3, 5, 0, 0, 1'b1, 1'b0, -1);

    // Backpressure on both sides.
    set_len(2, 4);
    do_burst(4'b0100, 0, 0, 1, 5, 1'b0, 1'b0, -1);

    // len=0, then maximum length with full-scale samples.
    set_len(0, 0);
    do_burst(4'b0001, 0, 0, 0, 2, 1'b0, 1'b0, -1);
    set_len(1, 255);
    do_burst(4'b0010, 1, 'hFFFF, 0, 0, 1'b1, 1'b0, -1);
    check("max_len_data", 64'(bus.res_data), 64'hFF01);

    // Reset mid-ACCUM after 2 of 4 beats.
    set_len(1, 4);
    do_burst(4'b0010, 1, 99, 0, 0, 1'b0, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus.req      = '0;
    bus.in_valid = 1'b0;
    last_id      = N_REQ - 1;
    @(negedge clk);
    rst_n = 1'b1;
    set_len(0, 1);
    set_len(1, 1);
    do_burst(4'b0011, 1, 7, 0, 0, 1'b1, 1'b0, -1);
    do_burst(4'b0010, 1, 7, 0, 0, 1'b1, 1'b0, -1);
    check("post_reset_data", 64'(bus.res_data), 64'd7);

    // Random traffic.
    repeat (40) begin
      for (int i = 0; i < N_REQ; i++)
        set_len(i, ($urandom_range(3) == 0) ? $urandom_range(40) : $urandom_range(6));
      do_burst(N_REQ'($urandom_range(15, 1)), 0, 0, 2, $urandom_range(3),
               1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end

    bus.req = '0;
    repeat (3) @(negedge clk);
    check("final_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
